// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM states and word helpers.
package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} kexp_state_t;

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/inv_mix_word.sv
// InvMixColumns on a single 32-bit column (MS byte is row 0).
module inv_mix_word (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9, b, d, e of a byte built from the x2/x4/x8 chain.
  function automatic logic [31:0] mults(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
  endfunction

  logic [31:0] m0, m1, m2, m3;

  assign m0 = mults(col_in[31:24]);
  assign m1 = mults(col_in[23:16]);
  assign m2 = mults(col_in[15:8]);
  assign m3 = mults(col_in[7:0]);

  // Byte fields of mN: [31:24]=9, [23:16]=b, [15:8]=d, [7:0]=e
  assign col_out[31:24] = m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24];
  assign col_out[23:16] = m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8];
  assign col_out[15:8]  = m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16];
  assign col_out[7:0]   = m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0];

endmodule

// File: rtl/s_box.sv
// Four parallel AES forward S-box lookups on a 32-bit word.
module s_box (
  input  logic [31:0] row_in,
  output logic [31:0] row_out
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign row_out = {SBOX[row_in[31:24]], SBOX[row_in[23:16]],
                    SBOX[row_in[15:8]],  SBOX[row_in[7:0]]};

endmodule

// File: rtl/inv_key_expand.sv
// AES-128 reverse key schedule: loads round key 10, derives keys 9..0 into a readable key file.
// Build option INV_KEY_EQUIV_EN stores InvMixColumns'd keys 1..9 for the equivalent inverse cipher.
module inv_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] last_key,
  input  logic [1:0]  r_index,
  input  logic [3:0]  round_key_num,
  output logic [31:0] round_key,
  output logic        rk_valid,
  output logic [3:0]  rk_round,
  output logic        busy,
  output logic        done
);

  kexp_state_t  state_q, state_d;
  logic [1:0]   load_cnt_q, load_cnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] key_file_q [0:NUM_ROUNDS];
  logic [127:0] key_file_d [0:NUM_ROUNDS];
  logic         rk_valid_q, rk_valid_d;
  logic [3:0]   rk_round_q, rk_round_d;

  logic [127:0] cur_key, derived_key, store_key, sel_key;
  logic [31:0]  p0, p1, p2, p3, rot_p3, sub_rot;
  logic [7:0]   rcon_byte;
  logic [6:0]   load_lsb;

  assign load_lsb = {2'd3 - load_cnt_q, 5'd0};

`ifdef INV_KEY_EQUIV_EN
  logic [127:0] work_q, work_d, mixed_key;

  assign cur_key = work_q;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    inv_mix_word u_inv_mix_word (
      .col_in  (derived_key[c*32 +: 32]),
      .col_out (mixed_key[c*32 +: 32])
    );
  end

  // Key 0 is used unmodified by the last decryption round.
  assign store_key = (rnd_q == 4'd1) ? derived_key : mixed_key;
`else
  assign cur_key   = key_file_q[rnd_q];
  assign store_key = derived_key;
`endif

  // Forward recurrence w[i] = w[i-4] ^ f(w[i-1]) solved for w[i-4].
  assign p3        = cur_key[31:0]  ^ cur_key[63:32];
  assign p2        = cur_key[63:32] ^ cur_key[95:64];
  assign p1        = cur_key[95:64] ^ cur_key[127:96];
  assign rot_p3    = rot_word(p3);
  assign rcon_byte = (rnd_q >= 4'd1 && rnd_q <= 4'd10) ? RCON[rnd_q] : 8'h00;

  s_box u_s_box (
    .row_in  (rot_p3),
    .row_out (sub_rot)
  );

  assign p0          = cur_key[127:96] ^ sub_rot ^ {rcon_byte, 24'h0};
  assign derived_key = {p0, p1, p2, p3};

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    rnd_d      = rnd_q;
    key_file_d = key_file_q;
    rk_valid_d = 1'b0;
    rk_round_d = rk_round_q;
`ifdef INV_KEY_EQUIV_EN
    work_d     = work_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          load_cnt_d = 2'd0;
        end
      end
      LOAD: begin
        key_file_d[NUM_ROUNDS][load_lsb +: 32] = last_key;
`ifdef INV_KEY_EQUIV_EN
        work_d[load_lsb +: 32] = last_key;
`endif
        load_cnt_d = load_cnt_q + 2'd1;
        if (load_cnt_q == 2'd3) begin
          state_d = RUN;
          rnd_d   = 4'(NUM_ROUNDS);
        end
      end
      RUN: begin
        key_file_d[rnd_q - 4'd1] = store_key;
`ifdef INV_KEY_EQUIV_EN
        work_d = derived_key;
`endif
        rk_valid_d = 1'b1;
        rk_round_d = rnd_q - 4'd1;
        rnd_d      = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      load_cnt_q <= 2'd0;
      rnd_q      <= 4'd0;
      rk_valid_q <= 1'b0;
      rk_round_q <= 4'd0;
      for (int i = 0; i <= NUM_ROUNDS; i++) key_file_q[i] <= '0;
`ifdef INV_KEY_EQUIV_EN
      work_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      rnd_q      <= rnd_d;
      rk_valid_q <= rk_valid_d;
      rk_round_q <= rk_round_d;
      key_file_q <= key_file_d;
`ifdef INV_KEY_EQUIV_EN
      work_q     <= work_d;
`endif
    end
  end

  always_comb begin
    sel_key = '0;
    if (round_key_num <= 4'(NUM_ROUNDS)) sel_key = key_file_q[round_key_num];
  end

  assign round_key = sel_key[{r_index, 5'd0} +: 32];
  assign rk_valid  = rk_valid_q;
  assign rk_round  = rk_round_q;
  assign busy      = (state_q == LOAD) || (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule
